trap_csr_sequencer: RTL

Sequencer that owns the single CSR-file write port and read address and time-shares them between three requesters: CSR instructions, trap entry, and mret. Trap entry is run as a fixed multi-cycle write sequence (mstatus, mepc, mcause, optional mtval), followed by a redirect to mtvec. mret is run as an mstatus restore plus a redirect to mepc. Sits in the MEM stage beside the CSR register file; drives the pipeline flush, stall and PC-redirect signals.

---
 rtl/trap_csr_pkg.sv | 33 +++
 rtl/trap_csr_sequencer_cause.sv | 35 +++
 rtl/trap_csr_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/trap_csr_pkg.sv
// Shared state encoding and CSR constants for the trap/mret/CSR write-port sequencer.
package trap_csr_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    T_STAT  = 3'd1,
    T_EPC   = 3'd2,
    T_CAUSE = 3'd3,
    T_TVAL  = 3'd4,
    T_JUMP  = 3'd5,
    M_STAT  = 3'd6,
    M_JUMP  = 3'd7
  } seq_state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [31:0] CAUSE_ILLEGAL     = 32'd2;
  localparam logic [31:0] CAUSE_LOAD_FAULT  = 32'd5;
  localparam logic [31:0] CAUSE_STORE_FAULT = 32'd7;
  localparam logic [31:0] CAUSE_ECALL_M     = 32'd11;

  localparam logic [1:0] WSC_WRITE = 2'b01;
  localparam logic [1:0] WSC_SET   = 2'b10;
  localparam logic [1:0] WSC_CLEAR = 2'b11;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

endpackage

// File: rtl/trap_csr_sequencer_cause.sv
// Fixed-priority encoder from the MEM-stage exception/interrupt flags to the mcause value.
module trap_cause_encoder
  import trap_csr_pkg::*;
#(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  INT_CAUSE = XLEN'(32'h8000000B)
) (
  input  logic            illegal_inst,
  input  logic            l_access_fault,
  input  logic            s_access_fault,
  input  logic            ecall_m,
  input  logic            irq,
  output logic            trap,
  output logic [XLEN-1:0] cause
);

  assign trap = illegal_inst | l_access_fault | s_access_fault | ecall_m | irq;

  // Synchronous exceptions outrank the (already MIE-masked) interrupt
  always_comb begin
    cause = '0;
    if (illegal_inst) begin
      cause = XLEN'(CAUSE_ILLEGAL);
    end else if (l_access_fault) begin
      cause = XLEN'(CAUSE_LOAD_FAULT);
    end else if (s_access_fault) begin
      cause = XLEN'(CAUSE_STORE_FAULT);
    end else if (ecall_m) begin
      cause = XLEN'(CAUSE_ECALL_M);
    end else begin
      cause = INT_CAUSE;
    end
  end

endmodule

// File: rtl/trap_csr_sequencer.sv
// Owns the CSR write port and read address; runs trap entry, mret and CSR instructions.
// Optional mtval write on trap entry is enabled by defining TRAP_CSR_MTVAL_EN.
module trap_csr_sequencer
  import trap_csr_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] INT_CAUSE  = XLEN'(32'h8000000B),
  parameter logic [XLEN-1:0] EPC_OFFSET = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            csr_rw_in,
  input  logic [1:0]      csr_wsc_mode_in,
  input  logic            csr_w_imm_mux,
  input  logic [11:0]     csr_rw_addr_in,
  input  logic [XLEN-1:0] csr_w_data_reg,
  input  logic [4:0]      csr_w_data_imm,
  input  logic            interrupt,
  input  logic            illegal_inst,
  input  logic            l_access_fault,
  input  logic            s_access_fault,
  input  logic            ecall_m,
  input  logic            mret,
  input  logic [XLEN-1:0] epc_cur,
  input  logic [XLEN-1:0] fault_addr,
  input  logic [XLEN-1:0] mstatus,
  input  logic [XLEN-1:0] csr_rdata,
  output logic [11:0]     csr_raddr,
  output logic            csr_w,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic [1:0]      csr_wsc,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            regwrite_cancel,
  output logic            busy
);

  seq_state_e      state_r;
  seq_state_e      next_state_s;
  logic            trap_s;
  logic [XLEN-1:0] cause_s;
  logic [XLEN-1:0] cause_r;
  logic [XLEN-1:0] epc_r;
  logic [XLEN-1:0] csr_op_data_s;
  logic            csr_op_write_s;

`ifdef TRAP_CSR_MTVAL_EN
  logic [XLEN-1:0] tval_r;
`else
  logic unused_s;
  assign unused_s = ^{fault_addr, CSR_MTVAL};
`endif

  function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r               = m;
    r[MSTATUS_MPIE] = m[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r               = m;
    r[MSTATUS_MIE]  = m[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

  trap_cause_encoder #(
    .XLEN      (XLEN),
    .INT_CAUSE (INT_CAUSE)
  ) u_cause (
    .illegal_inst   (illegal_inst),
    .l_access_fault (l_access_fault),
    .s_access_fault (s_access_fault),
    .ecall_m        (ecall_m),
    .irq            (interrupt & mstatus[MSTATUS_MIE]),
    .trap           (trap_s),
    .cause          (cause_s)
  );

  assign csr_op_data_s  = csr_w_imm_mux ? {{(XLEN-5){1'b0}}, csr_w_data_imm} : csr_w_data_reg;
  // Set/clear with a zero operand has no architectural effect, so no write is issued
  assign csr_op_write_s = !(((csr_wsc_mode_in == WSC_SET) || (csr_wsc_mode_in == WSC_CLEAR)) &&
                            (csr_op_data_s == '0));
  assign busy           = (state_r != IDLE);

  // State register and trap context captured in the accepting cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cause_r <= '0;
      epc_r   <= '0;
`ifdef TRAP_CSR_MTVAL_EN
      tval_r  <= '0;
`endif
    end else begin
      state_r <= next_state_s;
      if ((state_r == IDLE) && trap_s) begin
        cause_r <= cause_s;
        epc_r   <= epc_cur;
`ifdef TRAP_CSR_MTVAL_EN
        tval_r  <= (!illegal_inst && (l_access_fault || s_access_fault)) ? fault_addr : '0;
`endif
      end
    end
  end

  // Next state plus CSR port, redirect and flush drive
  always_comb begin
    next_state_s    = state_r;
    csr_raddr       = 12'h000;
    csr_w           = 1'b0;
    csr_waddr       = 12'h000;
    csr_wdata       = '0;
    csr_wsc         = 2'b00;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    flush           = 1'b0;
    regwrite_cancel = 1'b0;
    case (state_r)
      IDLE: begin
        if (trap_s) begin
          next_state_s    = T_STAT;
          flush           = 1'b1;
          regwrite_cancel = 1'b1;
        end else if (mret) begin
          next_state_s = M_STAT;
          flush        = 1'b1;
        end else if (csr_rw_in) begin
          csr_raddr = csr_rw_addr_in;
          if (csr_op_write_s) begin
            csr_w     = 1'b1;
            csr_waddr = csr_rw_addr_in;
            csr_wdata = csr_op_data_s;
            csr_wsc   = csr_wsc_mode_in;
          end else begin
            csr_w = 1'b0;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      T_STAT: begin
        csr_w        = 1'b1;
        csr_waddr    = CSR_MSTATUS;
        csr_wdata    = mstatus_on_trap(mstatus);
        csr_wsc      = WSC_WRITE;
        next_state_s = T_EPC;
      end
      T_EPC: begin
        csr_w        = 1'b1;
        csr_waddr    = CSR_MEPC;
        csr_wdata    = epc_r - EPC_OFFSET;
        csr_wsc      = WSC_WRITE;
        next_state_s = T_CAUSE;
      end
      T_CAUSE: begin
        csr_w        = 1'b1;
        csr_waddr    = CSR_MCAUSE;
        csr_wdata    = cause_r;
        csr_wsc      = WSC_WRITE;
`ifdef TRAP_CSR_MTVAL_EN
        next_state_s = T_TVAL;
`else
        next_state_s = T_JUMP;
`endif
      end
      T_TVAL: begin
`ifdef TRAP_CSR_MTVAL_EN
        csr_w        = 1'b1;
        csr_waddr    = CSR_MTVAL;
        csr_wdata    = tval_r;
        csr_wsc      = WSC_WRITE;
        next_state_s = T_JUMP;
`else
        next_state_s = IDLE;
`endif
      end
      T_JUMP: begin
        csr_raddr      = CSR_MTVEC;
        redirect_valid = 1'b1;
        redirect_pc    = {csr_rdata[XLEN-1:2], 2'b00};
        next_state_s   = IDLE;
      end
      M_STAT: begin
        csr_w        = 1'b1;
        csr_waddr    = CSR_MSTATUS;
        csr_wdata    = mstatus_on_mret(mstatus);
        csr_wsc      = WSC_WRITE;
        next_state_s = M_JUMP;
      end
      M_JUMP: begin
        csr_raddr      = CSR_MEPC;
        redirect_valid = 1'b1;
        redirect_pc    = csr_rdata;
        next_state_s   = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

endmodule
